// File: rtl/fir_pkg.sv
// fir_pkg: shared state encoding, sizing constants and circular-index helper for the FIR sequencer
package fir_pkg;
  localparam int Tape_Num = 11;
  localparam int ADDR_SHIFT = 2;
  typedef enum logic [2:0] {IDLE, CLEAR, WAIT_IN, MAC, DRAIN, OUT} state_t;
  function automatic logic [3:0] wrap_sub(input logic [3:0] a, input logic [3:0] b);
    return (a >= b) ? a - b : a + 4'(Tape_Num) - b;
  endfunction
endpackage

// File: rtl/fir_seq_ctrl_mac.sv
// fir_mac: registered 32-bit wrapping multiply-accumulate with synchronous clear
module fir_mac (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] acc
);
  logic [31:0] acc_q, acc_d;
  always_comb acc_d = clr ? '0 : en ? acc_q + 32'($signed(a) * $signed(b)) : acc_q;
  always_ff @(posedge clk) acc_q <= rst ? '0 : acc_d;
  assign acc = acc_q;
endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequencer that owns the tap/data BRAMs, runs one 11-tap MAC per stream sample
// and emits results on the stream master
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ap_start,
  input  logic [31:0]            data_length,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   tap_own,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do,
  output logic                   data_EN,
  output logic [3:0]             data_WE,
  output logic [pADDR_WIDTH-1:0] data_A,
  output logic [pDATA_WIDTH-1:0] data_Di,
  input  logic [pDATA_WIDTH-1:0] data_Do
);
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d, wptr_q, wptr_d;
  logic [31:0] cnt_q, cnt_d, acc;
  logic tlast_q, tlast_d, done_q, done_d, mac_clr, mac_en, last;

  function automatic logic [pADDR_WIDTH-1:0] word_addr(input logic [3:0] i);
    return pADDR_WIDTH'(i) << ADDR_SHIFT;
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    wptr_d = wptr_q;
    cnt_d = cnt_q;
    tlast_d = tlast_q;
    done_d = done_q;
    tap_EN = 1'b0;
    tap_A = '0;
    data_EN = 1'b0;
    data_WE = 4'h0;
    data_A = '0;
    data_Di = '0;
    mac_clr = 1'b0;
    mac_en = (state_q == MAC && idx_q != 4'd0) || state_q == DRAIN;
    last = (data_length != 32'd0 && cnt_q + 32'd1 == data_length) || tlast_q;
    case (state_q)
      IDLE: if (ap_start) begin
        state_d = CLEAR;
        done_d = 1'b0;
        idx_d = '0;
        wptr_d = '0;
        cnt_d = '0;
      end
      CLEAR: begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A = word_addr(idx_q);
        idx_d = (idx_q == 4'(Tape_Num - 1)) ? 4'd0 : idx_q + 4'd1;
        state_d = (idx_q == 4'(Tape_Num - 1)) ? WAIT_IN : CLEAR;
      end
      WAIT_IN: if (ss_tvalid) begin
        data_EN = 1'b1;
        data_WE = 4'hF;
        data_A = word_addr(wptr_q);
        data_Di = ss_tdata;
        tlast_d = ss_tlast;
        mac_clr = 1'b1;
        idx_d = '0;
        state_d = MAC;
      end
      MAC: begin
        tap_EN = 1'b1;
        tap_A = word_addr(idx_q);
        data_EN = 1'b1;
        data_A = word_addr(wrap_sub(wptr_q, idx_q));
        idx_d = idx_q + 4'd1;
        state_d = (idx_q == 4'(Tape_Num - 1)) ? DRAIN : MAC;
      end
      DRAIN: state_d = OUT;
      OUT: if (sm_tready) begin
        wptr_d = (wptr_q == 4'(Tape_Num - 1)) ? 4'd0 : wptr_q + 4'd1;
        cnt_d = cnt_q + 32'd1;
        done_d = last;
        state_d = last ? IDLE : WAIT_IN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      wptr_q <= '0;
      cnt_q <= '0;
      tlast_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      wptr_q <= wptr_d;
      cnt_q <= cnt_d;
      tlast_q <= tlast_d;
      done_q <= done_d;
    end
  end

  // BRAM data lags its address by one cycle, so products land one state behind the issue
  fir_mac u_mac (
    .clk(axis_clk),
    .rst(axis_rst),
    .clr(mac_clr),
    .en(mac_en),
    .a(tap_Do),
    .b(data_Do),
    .acc(acc)
  );

  assign ap_idle = state_q == IDLE;
  assign ap_done = done_q;
  assign tap_own = state_q != IDLE;
  assign ss_tready = state_q == WAIT_IN;
  assign sm_tvalid = state_q == OUT;
  assign sm_tdata = sm_tvalid ? acc : '0;
  assign sm_tlast = sm_tvalid && last;
endmodule
